// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and opcode encoding.
package alu_pkg;

  localparam int unsigned WIDTH = 36;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU: add, subtract, and, or. Carry-out is discarded.
module ALU
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_e          i_ALUControlS,
  output logic [WIDTH-1:0] o_ALU_Result
);

  always_comb begin
    o_ALU_Result = '0;
    case (i_ALUControlS)
      ALU_ADD: o_ALU_Result = i_a + i_b;
      ALU_SUB: o_ALU_Result = i_a - i_b;
      ALU_AND: o_ALU_Result = i_a & i_b;
      ALU_OR:  o_ALU_Result = i_a | i_b;
      default: o_ALU_Result = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Two-stage registered request/response wrapper around ALU with result flags
// and a saturating overflow-event counter.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_a,
  input  logic [WIDTH-1:0] i_cmd_b,
  input  logic [TAG_W-1:0] i_cmd_tag,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic             o_rsp_zero,
  output logic             o_rsp_neg,
  output logic             o_rsp_ovf,
  output logic [CNT_W-1:0] o_ovf_count
);

  if (WIDTH != alu_pkg::WIDTH) begin : g_width_err
    $error("alu_sequencer: WIDTH must equal the ALU width");
  end

  // S1: operand register feeding the ALU
  logic             s1_v_q, s1_v_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  // S2: response register
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;
  logic             zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_r;
  logic             cmd_fire, rsp_fire, adv, ovf_calc;

  ALU u_alu (
    .i_a          (a_q),
    .i_b          (b_q),
    .i_ALUControlS(op_q),
    .o_ALU_Result (alu_r)
  );

  assign o_cmd_ready = !s1_v_q || !s2_v_q || i_rsp_ready;
  assign cmd_fire    = i_cmd_valid && o_cmd_ready;
  assign rsp_fire    = s2_v_q && i_rsp_ready;
  assign adv         = s1_v_q && (!s2_v_q || i_rsp_ready);

  always_comb begin
    ovf_calc = 1'b0;
    case (op_q)
      ALU_ADD: ovf_calc = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_r[WIDTH-1] != a_q[WIDTH-1]);
      ALU_SUB: ovf_calc = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_r[WIDTH-1] != a_q[WIDTH-1]);
      default: ovf_calc = 1'b0;
    endcase
  end

  always_comb begin
    s1_v_d = s1_v_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    tag1_d = tag1_q;
    s2_v_d = s2_v_q;
    res_d  = res_q;
    tag2_d = tag2_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;

    // Drain, advance and accept may all fire together; later writes win.
    if (rsp_fire) s2_v_d = 1'b0;
    if (adv) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b1;
      res_d  = alu_r;
      tag2_d = tag1_q;
      zero_d = (alu_r == '0);
      neg_d  = alu_r[WIDTH-1];
      ovf_d  = ovf_calc;
    end
    if (cmd_fire) begin
      s1_v_d = 1'b1;
      op_d   = alu_op_e'(i_cmd_op);
      a_d    = i_cmd_a;
      b_d    = i_cmd_b;
      tag1_d = i_cmd_tag;
    end
    if (rsp_fire && ovf_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_v_q <= 1'b0;
      op_q   <= ALU_ADD;
      a_q    <= '0;
      b_q    <= '0;
      tag1_q <= '0;
      s2_v_q <= 1'b0;
      res_q  <= '0;
      tag2_q <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      tag1_q <= tag1_d;
      s2_v_q <= s2_v_d;
      res_q  <= res_d;
      tag2_q <= tag2_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_rsp_valid  = s2_v_q;
  assign o_rsp_result = res_q;
  assign o_rsp_tag    = tag2_q;
  assign o_rsp_zero   = zero_q;
  assign o_rsp_neg    = neg_q;
  assign o_rsp_ovf    = ovf_q;
  assign o_ovf_count  = cnt_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Registered command/response front end for the combinational 36-bit `ALU`. It accepts tagged operation requests over a valid/ready handshake and drives the ALU's `i_a`, `i_b` and `i_ALUControlS` from a register stage. It captures `o_ALU_Result` into a response register, adds zero, negative and signed-overflow flags (the ALU has no overflow flag), and returns the result over a second valid/ready handshake. It also keeps a saturating overflow-event counter.

## Interface
Parameters:
- `WIDTH`, 36: datapath width. Must equal the ALU width; any other value is a configuration error.
- `TAG_W`, 4: width of the request tag that is carried through to the response.
- `CNT_W`, 16: width of the overflow-event counter.

Ports (one clock; reset is asynchronous and active-high):
- `i_clk`, in, 1: clock, rising edge.
- `i_rst`, in, 1: asynchronous active-high reset.
- `i_cmd_valid`, in, 1: request valid.
- `o_cmd_ready`, out, 1: request accepted when high together with `i_cmd_valid`.
- `i_cmd_op`, in, 2: opcode. 00 = ADD, 01 = SUB (a-b), 10 = AND, 11 = OR.
- `i_cmd_a`, in, WIDTH: operand A.
- `i_cmd_b`, in, WIDTH: operand B.
- `i_cmd_tag`, in, TAG_W: request tag.
- `o_rsp_valid`, out, 1: response valid.
- `i_rsp_ready`, in, 1: downstream accepts the response.
- `o_rsp_result`, out, WIDTH: ALU result.
- `o_rsp_tag`, out, TAG_W: tag of the request this response belongs to.
- `o_rsp_zero`, out, 1: result == 0.
- `o_rsp_neg`, out, 1: result[WIDTH-1].
- `o_rsp_ovf`, out, 1: two's-complement overflow. ADD and SUB only; 0 for AND and OR.
- `o_ovf_count`, out, CNT_W: number of responses delivered with `o_rsp_ovf` = 1, saturating.

## Operation
- Two-stage pipeline:
  - S1 is the operand register: op, a, b, tag, valid. It feeds the ALU directly.
  - S2 is the response register: result, tag, flags, valid.
- Request handshake: transfer when `i_cmd_valid && o_cmd_ready`.
  - `o_cmd_ready` = !s1_v || !s2_v || `i_rsp_ready`.
  - Combinational from `i_rsp_ready`; there is no path from `i_cmd_valid` to `o_cmd_ready`.
- S1 advances to S2 when s1_v && (!s2_v || `i_rsp_ready`).
- S2 captures the result and computes flags from the S1 operands and the ALU result r:
  - ADD: ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]).
  - SUB: ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]).
- Result arithmetic is modulo 2^WIDTH; carry-out is discarded.
- The response is held stable while `o_rsp_valid && !i_rsp_ready`.
- `o_ovf_count` increments on each response handshake with `o_rsp_ovf` = 1. It holds at 2^CNT_W-1.
- Simultaneous events in one cycle are all legal and must all take effect: response drain, S1 to S2 advance, and new request accept.
- The block never drops, reorders or duplicates requests. Responses come out in acceptance order.

## Timing
- Reset values:
  - s1_v = s2_v = 0.
  - `o_rsp_valid` = 0; `o_rsp_result`, `o_rsp_tag` and all flags = 0.
  - `o_ovf_count` = 0.
  - `o_cmd_ready` = 1 (follows from s1_v = 0).
- Latency: a request accepted at edge N gives `o_rsp_valid` = 1 after edge N+1, provided S2 was free or draining.
- Throughput: one request per cycle while `i_rsp_ready` is held high.
- Backpressure: with `i_rsp_ready` = 0, at most two requests are buffered (S1 and S2). `o_cmd_ready` then drops to 0 in the cycle after the second acceptance.
- Reset asserted mid-operation: all in-flight requests are discarded immediately (asynchronous). After deassertion the first accepted request behaves exactly as it would after power-up.
- The ALU is purely combinational between S1 and S2. There is no multicycle path.

## Structure
- Shared package `alu_pkg`:
  - `WIDTH` = 36.
  - Opcode constants `ALU_ADD` = 2'b00, `ALU_SUB` = 2'b01, `ALU_AND` = 2'b10, `ALU_OR` = 2'b11.
  - The ALU and this block import it.
- Single sub-module: the existing `ALU`, instantiated once and driven from S1.
- Flag logic and counter live in `alu_sequencer` itself.

## Test plan
- Basic ADD and SUB:
  - ADD 435+245, tag 3, `i_rsp_ready` = 1 → after 2 edges: result 680, tag 3, zero 0, neg 0, ovf 0.
  - SUB 5-6 → result 0xFFFFFFFFF, neg 1, ovf 0.
  - SUB 2-2 → result 0, zero 1.
- Overflow and counter:
  - ADD 0x7FFFFFFFF+1 → result 0x800000000, ovf 1, `o_ovf_count` 1.
  - ADD 0xFFFFFFFFF+1 → result 0, zero 1, ovf 0.
  - SUB 0x800000000-1 → result 0x7FFFFFFFF, ovf 1, count 2.
- Logic ops: AND 2&7 → 2; OR 8|11 → 11; ovf 0 for both even when operand sign bits would trigger it under ADD.
- Streaming: 8 back-to-back requests, tags 0..7, ready always high → 8 consecutive responses in tag order, one per cycle, first after 2 edges.
- Backpressure: hold `i_rsp_ready` = 0 and offer 3 requests →
  - exactly 2 accepted and `o_cmd_ready` goes low;
  - the response holds tag 0 stably;
  - releasing ready drains tags 0, 1, 2 in order with no loss or duplication.
- Reset mid-flight: assert `i_rst` with S1 and S2 full → all outputs are reset values immediately. After release, ADD 1+1 → result 2 with latency 2.
